// File: rtl/inst_buffer.sv
// inst_buffer: circular fetch-to-decode instruction queue, up to two pushes and two pops per cycle.
// Entry storage is not reset; only pointers and count are, so stale entries are never visible.
module inst_buffer #(
    parameter int DEPTH = 16,
    parameter int EXC_W = 5
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             fetch_valid0,
    input  logic             fetch_valid1,
    input  logic [31:0]      fetch_PC0,
    input  logic [31:0]      fetch_PC1,
    input  logic [31:0]      fetch_inst0,
    input  logic [31:0]      fetch_inst1,
    input  logic             fetch_predict0,
    input  logic             fetch_predict1,
    input  logic [31:0]      fetch_predict_target0,
    input  logic [31:0]      fetch_predict_target1,
    input  logic [EXC_W-1:0] fetch_excode0,
    input  logic [EXC_W-1:0] fetch_excode1,
    input  logic [63:0]      fetch_RAS,
    output logic             fetch_stall,
    input  logic             decode_busy,
    output logic             buffer_valid0,
    output logic             buffer_valid1,
    output logic [31:0]      buffer_PC0,
    output logic [31:0]      buffer_PC1,
    output logic [31:0]      buffer_inst0,
    output logic [31:0]      buffer_inst1,
    output logic             buffer_predict0,
    output logic             buffer_predict1,
    output logic [31:0]      buffer_predict_target0,
    output logic [31:0]      buffer_predict_target1,
    output logic [EXC_W-1:0] buffer_excode0,
    output logic [EXC_W-1:0] buffer_excode1,
    output logic [63:0]      buffer_RAS
);
    localparam int PW = $clog2(DEPTH);

    logic [31:0]      pc_q   [DEPTH];
    logic [31:0]      inst_q [DEPTH];
    logic [31:0]      tgt_q  [DEPTH];
    logic             pred_q [DEPTH];
    logic [EXC_W-1:0] exc_q  [DEPTH];
    logic [63:0]      ras_q  [DEPTH];

    logic [PW-1:0] head, tail, head1, tail1;
    logic [PW:0]   count, push_n, pop_n;
    logic          push_en;

    assign head1 = head + PW'(1);
    assign tail1 = tail + PW'(1);
    assign fetch_stall = count > (PW+1)'(DEPTH - 2);
    assign push_en = resetn && !flush && !fetch_stall;
    assign push_n = push_en ? (PW+1)'(fetch_valid0) + (PW+1)'(fetch_valid1) : '0;
    assign pop_n = decode_busy ? '0 : (PW+1)'(buffer_valid0) + (PW+1)'(buffer_valid1);

    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + pop_n[PW-1:0];
            tail  <= tail + push_n[PW-1:0];
            count <= count + push_n - pop_n;
        end
    end

    // A lone slot-1 push is compacted into the tail entry.
    always_ff @(posedge clk) begin
        if (push_en && (fetch_valid0 || fetch_valid1)) begin
            pc_q[tail]   <= fetch_valid0 ? fetch_PC0 : fetch_PC1;
            inst_q[tail] <= fetch_valid0 ? fetch_inst0 : fetch_inst1;
            pred_q[tail] <= fetch_valid0 ? fetch_predict0 : fetch_predict1;
            tgt_q[tail]  <= fetch_valid0 ? fetch_predict_target0 : fetch_predict_target1;
            exc_q[tail]  <= fetch_valid0 ? fetch_excode0 : fetch_excode1;
            ras_q[tail]  <= fetch_RAS;
            if (fetch_valid0 && fetch_valid1) begin
                pc_q[tail1]   <= fetch_PC1;
                inst_q[tail1] <= fetch_inst1;
                pred_q[tail1] <= fetch_predict1;
                tgt_q[tail1]  <= fetch_predict_target1;
                exc_q[tail1]  <= fetch_excode1;
                ras_q[tail1]  <= fetch_RAS;
            end
        end
    end

    assign buffer_valid0          = count != '0;
    assign buffer_valid1          = count > (PW+1)'(1);
    assign buffer_PC0             = buffer_valid0 ? pc_q[head]   : '0;
    assign buffer_inst0           = buffer_valid0 ? inst_q[head] : '0;
    assign buffer_predict0        = buffer_valid0 ? pred_q[head] : 1'b0;
    assign buffer_predict_target0 = buffer_valid0 ? tgt_q[head]  : '0;
    assign buffer_excode0         = buffer_valid0 ? exc_q[head]  : '0;
    assign buffer_RAS             = buffer_valid0 ? ras_q[head]  : '0;
    assign buffer_PC1             = buffer_valid1 ? pc_q[head1]   : '0;
    assign buffer_inst1           = buffer_valid1 ? inst_q[head1] : '0;
    assign buffer_predict1        = buffer_valid1 ? pred_q[head1] : 1'b0;
    assign buffer_predict_target1 = buffer_valid1 ? tgt_q[head1]  : '0;
    assign buffer_excode1         = buffer_valid1 ? exc_q[head1]  : '0;
endmodule

// File: tb/tb_inst_buffer.sv
// tb_inst_buffer: directed and random stimulus for inst_buffer against a queue-based reference model.
module tb_inst_buffer;
    localparam int DEPTH = 16;
    localparam int EXC_W = 5;

    typedef struct packed {
        logic [31:0]      pc;
        logic [31:0]      inst;
        logic             pred;
        logic [31:0]      tgt;
        logic [EXC_W-1:0] exc;
        logic [63:0]      ras;
    } ent_t;

    logic clk = 1'b0, resetn = 1'b0, flush = 1'b0, decode_busy = 1'b1;
    logic fetch_valid0 = 1'b0, fetch_valid1 = 1'b0;
    logic [31:0] fetch_PC0 = '0, fetch_PC1 = '0, fetch_inst0 = '0, fetch_inst1 = '0;
    logic fetch_predict0 = 1'b0, fetch_predict1 = 1'b0;
    logic [31:0] fetch_predict_target0 = '0, fetch_predict_target1 = '0;
    logic [EXC_W-1:0] fetch_excode0 = '0, fetch_excode1 = '0;
    logic [63:0] fetch_RAS = '0;
    logic fetch_stall, buffer_valid0, buffer_valid1;
    logic [31:0] buffer_PC0, buffer_PC1, buffer_inst0, buffer_inst1;
    logic buffer_predict0, buffer_predict1;
    logic [31:0] buffer_predict_target0, buffer_predict_target1;
    logic [EXC_W-1:0] buffer_excode0, buffer_excode1;
    logic [63:0] buffer_RAS;

    int tests = 0, fails = 0;
    ent_t q[$];

    inst_buffer #(.DEPTH(DEPTH), .EXC_W(EXC_W)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .fetch_valid0(fetch_valid0), .fetch_valid1(fetch_valid1),
        .fetch_PC0(fetch_PC0), .fetch_PC1(fetch_PC1),
        .fetch_inst0(fetch_inst0), .fetch_inst1(fetch_inst1),
        .fetch_predict0(fetch_predict0), .fetch_predict1(fetch_predict1),
        .fetch_predict_target0(fetch_predict_target0), .fetch_predict_target1(fetch_predict_target1),
        .fetch_excode0(fetch_excode0), .fetch_excode1(fetch_excode1),
        .fetch_RAS(fetch_RAS), .fetch_stall(fetch_stall), .decode_busy(decode_busy),
        .buffer_valid0(buffer_valid0), .buffer_valid1(buffer_valid1),
        .buffer_PC0(buffer_PC0), .buffer_PC1(buffer_PC1),
        .buffer_inst0(buffer_inst0), .buffer_inst1(buffer_inst1),
        .buffer_predict0(buffer_predict0), .buffer_predict1(buffer_predict1),
        .buffer_predict_target0(buffer_predict_target0), .buffer_predict_target1(buffer_predict_target1),
        .buffer_excode0(buffer_excode0), .buffer_excode1(buffer_excode1),
        .buffer_RAS(buffer_RAS)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Whole visible output state versus the model's two oldest entries.
    task automatic check_model(input string tag);
        ent_t s0 = '0, s1 = '0;
        logic [269:0] obs, exp;
        if (q.size() >= 1) s0 = q[0];
        if (q.size() >= 2) s1 = q[1];
        obs = {buffer_valid0, buffer_PC0, buffer_inst0, buffer_predict0, buffer_predict_target0,
               buffer_excode0, buffer_RAS, buffer_valid1, buffer_PC1, buffer_inst1, buffer_predict1,
               buffer_predict_target1, buffer_excode1};
        exp = {q.size() >= 1, s0.pc, s0.inst, s0.pred, s0.tgt, s0.exc, s0.ras,
               q.size() >= 2, s1.pc, s1.inst, s1.pred, s1.tgt, s1.exc};
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s outputs observed=%h expected=%h", tag, obs, exp);
        end
        tests++;
        assert (fetch_stall === (q.size() > DEPTH - 2)) else begin
            fails++;
            $error("FAIL %s stall observed=%b expected=%b", tag, fetch_stall, q.size() > DEPTH - 2);
        end
    endtask

    task automatic cycle(input string tag);
        bit   stall = q.size() > DEPTH - 2;
        int   popn;
        ent_t e0 = {fetch_PC0, fetch_inst0, fetch_predict0, fetch_predict_target0, fetch_excode0, fetch_RAS};
        ent_t e1 = {fetch_PC1, fetch_inst1, fetch_predict1, fetch_predict_target1, fetch_excode1, fetch_RAS};
        @(posedge clk);
        if (!resetn || flush) q.delete();
        else begin
            popn = decode_busy ? 0 : (q.size() >= 2 ? 2 : q.size());
            for (int i = 0; i < popn; i++) void'(q.pop_front());
            if (!stall && fetch_valid0) q.push_back(e0);
            if (!stall && fetch_valid1) q.push_back(e1);
        end
        #1 check_model(tag);
    endtask

    task automatic drive(input bit v0, input bit v1, input logic [31:0] p0, input logic [31:0] p1,
                         input bit busy, input bit fl, input string tag);
        fetch_valid0 = v0; fetch_valid1 = v1;
        fetch_PC0 = p0; fetch_PC1 = p1;
        fetch_inst0 = $urandom; fetch_inst1 = $urandom;
        fetch_predict0 = 1'($urandom); fetch_predict1 = 1'($urandom);
        fetch_predict_target0 = $urandom; fetch_predict_target1 = $urandom;
        fetch_excode0 = EXC_W'($urandom); fetch_excode1 = EXC_W'($urandom);
        fetch_RAS = {$urandom, $urandom};
        decode_busy = busy; flush = fl;
        cycle(tag);
        fetch_valid0 = 1'b0; fetch_valid1 = 1'b0; flush = 1'b0;
    endtask

    initial begin
        logic [63:0] ras_sent;
        resetn = 1'b0;
        drive(1, 1, 32'h10, 32'h14, 0, 0, "reset0");
        drive(0, 0, 0, 0, 1, 0, "reset1");
        chk("reset_valid0", 64'(buffer_valid0), 64'd0);
        chk("reset_stall", 64'(fetch_stall), 64'd0);
        resetn = 1'b1;

        drive(1, 1, 32'h100, 32'h104, 1, 0, "basic_push");
        ras_sent = fetch_RAS;
        chk("basic_pc0", 64'(buffer_PC0), 64'h100);
        chk("basic_pc1", 64'(buffer_PC1), 64'h104);
        chk("basic_ras", buffer_RAS, ras_sent);
        drive(1, 0, 32'h108, 0, 1, 0, "odd_push");
        drive(0, 0, 0, 0, 0, 0, "odd_pop_pair");
        chk("odd_pc0", 64'(buffer_PC0), 64'h108);
        chk("odd_valid1", 64'(buffer_valid1), 64'd0);
        drive(0, 0, 0, 0, 0, 0, "odd_pop_single");
        chk("odd_empty", {31'd0, buffer_valid0, buffer_PC0}, 64'd0);

        for (int i = 0; i < 7; i++) drive(1, 1, 32'h400 + 8 * i, 32'h404 + 8 * i, 1, 0, "fill_pair");
        chk("fill14_stall", 64'(fetch_stall), 64'd0);
        drive(1, 0, 32'h500, 0, 1, 0, "fill_single");
        chk("fill15_stall", 64'(fetch_stall), 64'd1);
        drive(0, 1, 0, 32'h600, 1, 0, "stalled_push");
        chk("stalled_still", 64'(fetch_stall), 64'd1);
        drive(1, 1, 32'h700, 32'h704, 1, 0, "stalled_pair");

        drive(0, 0, 0, 0, 0, 1, "flush_full");
        for (int i = 0; i < 15; i++) drive(1, 0, 32'h800 + 4 * i, 0, 0, 0, "walk_tail");
        drive(0, 0, 0, 0, 0, 0, "walk_head");
        drive(1, 1, 32'h900, 32'h904, 1, 0, "wrap_push_pair");
        chk("wrap_pc1", 64'(buffer_PC1), 64'h904);
        drive(0, 0, 0, 0, 0, 0, "wrap_pop_pair");

        for (int i = 0; i < 40; i++)
            drive(1'($urandom), 1'($urandom), $urandom, $urandom, $urandom_range(0, 2) == 0, 0, "random");

        drive(0, 0, 0, 0, 0, 1, "flush_prep");
        for (int i = 0; i < 3; i++) drive(1, 1, $urandom, $urandom, 1, 0, "cnt7_pair");
        drive(1, 0, $urandom, 0, 1, 0, "cnt7_single");
        drive(1, 1, $urandom, $urandom, 0, 1, "flush_collide");
        chk("flush_valid0", 64'(buffer_valid0), 64'd0);
        chk("flush_stall", 64'(fetch_stall), 64'd0);
        drive(1, 0, 32'h200, 0, 1, 0, "post_flush_push");
        chk("post_flush_pc0", 64'(buffer_PC0), 64'h200);

        for (int i = 0; i < 4; i++) drive(1, 1, $urandom, $urandom, 1, 0, "cnt9_pair");
        drive(1, 0, $urandom, 0, 1, 0, "cnt9_single");
        resetn = 1'b0;
        drive(1, 1, $urandom, $urandom, 0, 0, "mid_reset");
        resetn = 1'b1;
        chk("mid_reset_ras", buffer_RAS, 64'd0);
        drive(1, 1, 32'h300, 32'h304, 1, 0, "post_reset_push");
        chk("post_reset_pc0", 64'(buffer_PC0), 64'h300);
        chk("post_reset_pc1", 64'(buffer_PC1), 64'h304);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
